// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Packs op class, registers and a signed immediate into RV32I
//               lw/sw/addi/beq words through a 2-stage valid/ready pipeline,
//               tagging each word with a wrapping word address.
//               Optional feature macro: RANGE_CHECK_EN (immediate range check).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        in_op_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [31:0]       in_imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_instr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_err_o
);

  localparam logic [1:0]  C_OP_LW   = 2'd0;
  localparam logic [1:0]  C_OP_SW   = 2'd1;
  localparam logic [1:0]  C_OP_ADDI = 2'd2;
  localparam logic [1:0]  C_OP_BEQ  = 2'd3;
  localparam logic [31:0] C_NOP     = 32'h0000_0013;

  logic              s1_valid_q;
  logic [1:0]        s1_op_q;
  logic [4:0]        s1_rd_q;
  logic [4:0]        s1_rs1_q;
  logic [4:0]        s1_rs2_q;
  logic [31:0]       s1_imm_q;

  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_err_q;

  logic [31:0]       out_instr_d;
  logic              out_err_d;
  logic [11:0]       w_i12_word;
  logic              w_s2_load;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_s2_load  = s1_valid_q & (~out_valid_q | out_ready_i);
  assign in_ready_o = ~s1_valid_q | w_s2_load;
  assign w_in_fire  = in_valid_i & in_ready_o;
  assign w_out_fire = out_valid_q & out_ready_i;

  // Word offsets become byte offsets in the 12-bit field.
  assign w_i12_word = {s1_imm_q[9:0], 2'b00};

`ifdef RANGE_CHECK_EN
  logic w_fit_word;
  logic w_fit_12;
  assign w_fit_word = (&s1_imm_q[31:9])  | ~(|s1_imm_q[31:9]);
  assign w_fit_12   = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
`else
  logic w_unused_imm;
  assign w_unused_imm = &{1'b0, s1_imm_q[31:12]};
`endif

  always_comb begin
    out_instr_d = C_NOP;
    out_err_d   = 1'b0;
    case (s1_op_q)
      C_OP_LW:   out_instr_d = {w_i12_word, s1_rs1_q, 3'b010, s1_rd_q, 7'b0000011};
      C_OP_SW:   out_instr_d = {w_i12_word[11:5], s1_rs2_q, s1_rs1_q, 3'b010,
                                w_i12_word[4:0], 7'b0100011};
      C_OP_ADDI: out_instr_d = {s1_imm_q[11:0], s1_rs1_q, 3'b000, s1_rd_q, 7'b0010011};
      C_OP_BEQ:  out_instr_d = {s1_imm_q[11], s1_imm_q[9:4], s1_rs2_q, s1_rs1_q, 3'b000,
                                s1_imm_q[3:0], s1_imm_q[10], 7'b1100011};
      default:   out_instr_d = C_NOP;
    endcase
`ifdef RANGE_CHECK_EN
    if (((s1_op_q == C_OP_LW) || (s1_op_q == C_OP_SW)) ? ~w_fit_word : ~w_fit_12) begin
      out_instr_d = C_NOP;
      out_err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 2'd0;
      s1_rd_q     <= 5'd0;
      s1_rs1_q    <= 5'd0;
      s1_rs2_q    <= 5'd0;
      s1_imm_q    <= 32'd0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (clear_i) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      if (w_in_fire) begin
        s1_valid_q <= 1'b1;
        s1_op_q    <= in_op_i;
        s1_rd_q    <= in_rd_i;
        s1_rs1_q   <= in_rs1_i;
        s1_rs2_q   <= in_rs2_i;
        s1_imm_q   <= in_imm_i;
      end else if (w_s2_load) begin
        s1_valid_q <= 1'b0;
      end

      // S2 only changes when empty or drained, so a stalled word holds.
      if (w_s2_load) begin
        out_valid_q <= 1'b1;
        out_instr_q <= out_instr_d;
        out_err_q   <= out_err_d;
      end else if (w_out_fire) begin
        out_valid_q <= 1'b0;
      end

      if (w_out_fire) begin
        out_addr_q <= out_addr_q + 1'b1;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_instr_o = out_instr_q;
  assign out_addr_o  = out_addr_q;
  assign out_err_o   = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder (ADDR_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  localparam int AW = 4;

  logic          clock;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;

  int n_checks;
  int n_errors;

  instr_encoder #(.ADDR_W(AW)) u_dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_rd_i     (in_rd),
    .in_rs1_i    (in_rs1),
    .in_rs2_i    (in_rs2),
    .in_imm_i    (in_imm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_instr_o (out_instr),
    .out_addr_o  (out_addr),
    .out_err_o   (out_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_op  = op;
    in_rd  = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
  endtask

  // One word through an empty pipe; the following posedge is its output handshake.
  task automatic single(input string tag, input logic [1:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_err,
                        input logic [31:0] exp_addr);
    @(posedge clock); #1;
    drive(op, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    @(negedge clock);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_vld"},   {31'd0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, exp_instr);
    chk({tag, "_err"},   {31'd0, out_err}, {31'd0, exp_err});
    chk({tag, "_addr"},  {28'd0, out_addr}, exp_addr);
  endtask

  initial begin
    int oi;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr",  {28'd0, out_addr}, 32'd0);
    chk("rst_err",   {31'd0, out_err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    single("lw",      2'd0, 5'd5, 5'd2, 5'd0, 32'd3,          32'h00C12283, 1'b0, 32'd0);
    single("sw",      2'd1, 5'd0, 5'd2, 5'd6, 32'hFFFF_FFFF,  32'hFE612E23, 1'b0, 32'd1);
    single("addi",    2'd2, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,  32'hFFF00093, 1'b0, 32'd2);
    single("beq",     2'd3, 5'd0, 5'd1, 5'd2, 32'd4,          32'h00208463, 1'b0, 32'd3);
    single("lw_min",  2'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FE00,  32'h80002003, 1'b0, 32'd4);
    single("beq_min", 2'd3, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800,  32'h80000063, 1'b0, 32'd5);
`ifdef RANGE_CHECK_EN
    single("addi_ovf", 2'd2, 5'd0, 5'd0, 5'd0, 32'd2048,      32'h00000013, 1'b1, 32'd6);
`else
    single("addi_ovf", 2'd2, 5'd0, 5'd0, 5'd0, 32'd2048,      32'h80000013, 1'b0, 32'd6);
`endif
    single("addi_max", 2'd2, 5'd0, 5'd0, 5'd0, 32'd2047,      32'h7FF00013, 1'b0, 32'd7);
`ifdef RANGE_CHECK_EN
    single("sw_ovf",   2'd1, 5'd0, 5'd0, 5'd0, 32'd512,       32'h00000013, 1'b1, 32'd8);
`else
    single("sw_ovf",   2'd1, 5'd0, 5'd0, 5'd0, 32'd512,       32'h80002023, 1'b0, 32'd8);
`endif
    @(posedge clock);
    @(negedge clock);
    chk("drain_addr", {28'd0, out_addr}, 32'd9);

    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    chk("clr_addr",  {28'd0, out_addr}, 32'd0);
    chk("clr_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: three back-to-back inputs against a stalled consumer.
    out_ready = 1'b0;
    @(posedge clock); #1;
    drive(2'd2, 5'd1, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    @(negedge clock);
    chk("bp_rdyA", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    drive(2'd2, 5'd1, 5'd0, 5'd0, 32'd2);
    @(negedge clock);
    chk("bp_rdyB", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    drive(2'd2, 5'd1, 5'd0, 5'd0, 32'd3);
    @(negedge clock);
    chk("bp_vldA",   {31'd0, out_valid}, 32'd1);
    chk("bp_instrA", out_instr, 32'h00100093);
    chk("bp_addrA",  {28'd0, out_addr}, 32'd0);
    chk("bp_stallC", {31'd0, in_ready}, 32'd0);
    for (int s = 0; s < 2; s++) begin
      @(posedge clock);
      @(negedge clock);
      chk("bp_hold_rdy",   {31'd0, in_ready}, 32'd0);
      chk("bp_hold_instr", out_instr, 32'h00100093);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_instrB", out_instr, 32'h00200093);
    chk("bp_addrB",  {28'd0, out_addr}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk("bp_instrC", out_instr, 32'h00300093);
    chk("bp_addrC",  {28'd0, out_addr}, 32'd2);
    @(posedge clock);
    @(negedge clock);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_addr3", {28'd0, out_addr}, 32'd3);

    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;

    // 17 streamed words: addresses 0..15 then wrap to 0.
    oi = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (c < 17) begin
        drive(2'd2, 5'd1, 5'd0, 5'd0, c);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      if (out_valid) begin
        chk("wrap_instr", out_instr, 32'h00000093 | (oi << 20));
        chk("wrap_addr",  {28'd0, out_addr}, oi % 16);
        oi++;
      end
    end
    chk("wrap_count", oi, 32'd17);
    chk("wrap_last",  {28'd0, out_addr}, 32'd1);

    // Clear while an input and an output handshake coincide.
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      drive(2'd2, 5'd1, 5'd0, 5'd0, 32'd10 + c);
      in_valid = 1'b1;
      if (c == 3) clear = 1'b1;
    end
    @(negedge clock);
    chk("mclr_pre_vld", {31'd0, out_valid}, 32'd1);
    @(posedge clock); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("mclr_valid", {31'd0, out_valid}, 32'd0);
    chk("mclr_addr",  {28'd0, out_addr}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("mclr_discard", {31'd0, out_valid}, 32'd0);
    single("post_clr", 2'd2, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 32'd0);
    @(posedge clock); #1;

    // Asynchronous reset with a word sitting in S2.
    out_ready = 1'b0;
    drive(2'd2, 5'd1, 5'd0, 5'd0, 32'd7);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("pre_rst_vld",  {31'd0, out_valid}, 32'd1);
    chk("pre_rst_addr", {28'd0, out_addr}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    chk("arst_addr",  {28'd0, out_addr}, 32'd0);
    chk("arst_err",   {31'd0, out_err}, 32'd0);
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("arst_s1_gone", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
